// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// between the MEM stage and the backing memory path.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   read, write          CPU load/store requests, held until stall is low
//   address, data_in     CPU byte address and store data
//   data_out, stall      load data and MEM-stage hold (combinational)
//   mem_read, mem_write  backing read/write request (registered)
//   mem_addr, mem_wdata  backing word address and write data (registered)
//   mem_rdata, mem_ready backing read data and one-cycle completion pulse
module dcache_ctrl #(
    parameter int unsigned LINES = 256,
    parameter int unsigned WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        stall,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned IDX  = $clog2(LINES);
    localparam int unsigned OFFW = $clog2(WORDS);
    localparam int unsigned TAGW = 32 - IDX - OFFW - 2;

    typedef enum logic [1:0] {IDLE, REFILL, WTHRU, DONE} state_t;

    state_t             state_q;
    logic [OFFW-1:0]    cnt_q;
    logic               lat_hit_q;
    logic [LINES-1:0]   valid_q;
    logic [TAGW-1:0]    tag_q  [LINES];
    logic [31:0]        data_q [LINES*WORDS];

    logic [TAGW-1:0]    a_tag;
    logic [IDX-1:0]     a_idx;
    logic [OFFW-1:0]    a_off;
    logic               hit;
    logic [IDX-1:0]     line_idx;
    logic [OFFW-1:0]    cnt_d;
    logic [1:0]         unused_addr_bits;

    // CPU address split; byte offset bits are don't-care
    assign a_tag            = address[31:IDX+OFFW+2];
    assign a_idx            = address[IDX+OFFW+1:OFFW+2];
    assign a_off            = address[OFFW+1:2];
    assign unused_addr_bits = address[1:0];
    assign hit              = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

    // The registered mem_addr doubles as the latched tag/index/offset of
    // the in-flight access, so no separate address latch is kept.
    assign line_idx = mem_addr[IDX+OFFW+1:OFFW+2];
    assign cnt_d    = OFFW'(cnt_q + 1'b1);

    // Same-cycle hit data and stall towards the pipeline
    always_comb begin
        stall    = 1'b0;
        data_out = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (write) begin
                        stall = 1'b1;
                    end else if (read) begin
                        if (hit) begin
                            data_out = data_q[{a_idx, a_off}];
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                REFILL, WTHRU: stall = 1'b1;
                default: ;
            endcase
        end
    end

    // Controller FSM with registered backing-memory handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lat_hit_q <= 1'b0;
            valid_q   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // stores win over loads when both are requested
                    if (write) begin
                        lat_hit_q <= hit;
                        mem_write <= 1'b1;
                        mem_addr  <= {address[31:2], 2'b00};
                        mem_wdata <= data_in;
                        state_q   <= WTHRU;
                    end else if (read && !hit) begin
                        cnt_q    <= '0;
                        mem_read <= 1'b1;
                        mem_addr <= {address[31:OFFW+2], {(OFFW+2){1'b0}}};
                        state_q  <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        cnt_q <= cnt_d;
                        if (cnt_q == OFFW'(WORDS - 1)) begin
                            valid_q[line_idx] <= 1'b1;
                            mem_read          <= 1'b0;
                            mem_addr          <= '0;
                            state_q           <= IDLE;
                        end else begin
                            mem_addr <= {mem_addr[31:OFFW+2], cnt_d, 2'b00};
                        end
                    end
                end
                WTHRU: begin
                    if (mem_ready) begin
                        mem_write <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        state_q   <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line storage; a line only becomes usable once its valid bit is set,
    // so partial refills abandoned by reset are harmless.
    always_ff @(posedge clock) begin
        if (state_q == REFILL && mem_ready) begin
            data_q[{line_idx, cnt_q}] <= mem_rdata;
            if (cnt_q == OFFW'(WORDS - 1)) begin
                tag_q[line_idx] <= mem_addr[31:IDX+OFFW+2];
            end
        end else if (state_q == WTHRU && mem_ready && lat_hit_q) begin
            data_q[{line_idx, mem_addr[OFFW+1:2]}] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: table of CPU requests with expected
// stall length, backing handshakes and load data, plus hand-written
// sequences for slow memory, the DONE cycle and reset during a refill.
module tb_dcache_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        read, write;
    logic [31:0] address, data_in, data_out;
    logic        stall, mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;

    always #5 clock = ~clock;

    dcache_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .stall     (stall),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Backing memory model
    logic [31:0] bmem [logic [31:0]];

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return 32'h0;
    endfunction

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } hs_t;

    hs_t         hs_q[$];
    hs_t         hs_new;
    int          gap  = 0;
    int          gcnt = 0;
    logic        pend_prev = 1'b0;
    logic [31:0] prev_addr;
    logic        prev_wr;

    // Ready responder: gap idle cycles before each handshake
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clock);
            #1;
            if (reset || !(mem_read || mem_write)) begin
                mem_ready = 1'b0;
                gcnt      = 0;
            end else if (gcnt == gap) begin
                mem_ready = 1'b1;
                gcnt      = 0;
                mem_rdata = mem_read ? rd_mem(mem_addr) : 32'h0;
            end else begin
                mem_ready = 1'b0;
                gcnt++;
            end
        end
    end

    // Handshake logger and protocol checks
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_read || mem_write) begin
                check("rd_wr_exclusive", 32'(mem_read && mem_write), 32'h0);
                check("addr_aligned", 32'(mem_addr[1:0]), 32'h0);
            end
            if (pend_prev) begin
                check("stable_addr", mem_addr, prev_addr);
                check("stable_kind", 32'(mem_write), 32'(prev_wr));
            end
            if (mem_ready && (mem_read || mem_write)) begin
                hs_new.wr    = mem_write;
                hs_new.addr  = mem_addr;
                hs_new.wdata = mem_wdata;
                hs_q.push_back(hs_new);
                if (mem_write) bmem[mem_addr] = mem_wdata;
            end
            pend_prev = (mem_read || mem_write) && !mem_ready;
            prev_addr = mem_addr;
            prev_wr   = mem_write;
        end else begin
            pend_prev = 1'b0;
        end
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_stall;
        int          exp_hs;
        logic [31:0] exp_dout;
        logic [31:0] exp_base;
    } vec_t;

    vec_t vecs[15];

    // Apply one request, hold until stall drops, then compare
    task automatic run_vec(input string nm, input vec_t v);
        int          st;
        int          start;
        int          nhs;
        logic [31:0] dout;
        logic        to;
        st = 0;
        to = 1'b0;
        @(posedge clock);
        #1;
        read    = v.rd;
        write   = v.wr;
        address = v.addr;
        data_in = v.wdata;
        start   = hs_q.size();
        forever begin
            @(negedge clock);
            if (!stall) break;
            st++;
            if (st > 100) begin
                to = 1'b1;
                break;
            end
        end
        dout = data_out;
        @(posedge clock);
        #1;
        read  = 1'b0;
        write = 1'b0;
        if (to) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: stall still high after %0d cycles", nm, st);
        end
        nhs = hs_q.size() - start;
        check({nm, " stall_cycles"}, 32'(st), 32'(v.exp_stall));
        check({nm, " handshakes"}, 32'(nhs), 32'(v.exp_hs));
        check({nm, " data_out"}, dout, v.exp_dout);
        for (int k = 0; k < nhs && k < v.exp_hs; k++) begin
            check($sformatf("%s hs%0d addr", nm, k), hs_q[start+k].addr,
                  v.wr ? v.exp_base : v.exp_base + 32'(4 * k));
            check($sformatf("%s hs%0d kind", nm, k), 32'(hs_q[start+k].wr), 32'(v.wr));
            if (v.wr) check($sformatf("%s hs%0d wdata", nm, k), hs_q[start+k].wdata, v.wdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   start;
        int   n;
        vec_t v;

        bmem[32'h40] = 32'hA0; bmem[32'h44] = 32'hA1;
        bmem[32'h48] = 32'hA2; bmem[32'h4C] = 32'hA3;
        bmem[32'h10040] = 32'hC0; bmem[32'h10044] = 32'hC1;
        bmem[32'h10048] = 32'hC2; bmem[32'h1004C] = 32'hC3;
        bmem[32'h80] = 32'h80; bmem[32'h84] = 32'h81;
        bmem[32'h88] = 32'h82; bmem[32'h8C] = 32'h83;
        bmem[32'h200] = 32'hB0; bmem[32'h204] = 32'hB1;
        bmem[32'h208] = 32'hB2; bmem[32'h20C] = 32'hB3;
        bmem[32'h300] = 32'hD0; bmem[32'h304] = 32'hD1;
        bmem[32'h308] = 32'hD2; bmem[32'h30C] = 32'hD3;
        bmem[32'hFF0] = 32'hF0; bmem[32'hFF4] = 32'hF1;
        bmem[32'hFF8] = 32'hF2; bmem[32'hFFC] = 32'hF3;

        //            rd    wr    addr          wdata         stall hs dout          base
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        5, 4, 32'hA0,        32'h40};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,        0, 0, 32'hA2,        32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_004C, 32'h0,        0, 0, 32'hA3,        32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0044, 32'hDEADBEEF, 2, 1, 32'h0,         32'h44};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        0, 0, 32'hDEADBEEF,  32'h0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0001_0040, 32'h12345678, 2, 1, 32'h0,         32'h10040};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        0, 0, 32'hA0,        32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0001_0040, 32'h0,        5, 4, 32'h12345678,  32'h10040};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        5, 4, 32'hA0,        32'h40};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        0, 0, 32'hDEADBEEF,  32'h0};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_0080, 32'h55,       2, 1, 32'h0,         32'h80};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,        5, 4, 32'h55,        32'h80};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_008B, 32'h0,        0, 0, 32'h82,        32'h0};
        vecs[13] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,        5, 4, 32'hF3,        32'hFF0};
        vecs[14] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,        0, 0, 32'h0,         32'h0};

        // Reset state, with a missing read pending to show stall is held low
        reset   = 1'b1;
        read    = 1'b1;
        write   = 1'b0;
        address = 32'h40;
        data_in = 32'h0;
        #12;
        check("rst stall", 32'(stall), 32'h0);
        check("rst data_out", data_out, 32'h0);
        check("rst mem_read", 32'(mem_read), 32'h0);
        check("rst mem_write", 32'(mem_write), 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        read = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Slow memory: two idle cycles before every ready pulse
        gap = 2;
        v = '{1'b1, 1'b0, 32'h300, 32'h0, 13, 4, 32'hD0, 32'h300};
        run_vec("slowmem", v);
        gap = 0;

        // Requests present during DONE are ignored
        @(posedge clock);
        #1;
        write   = 1'b1;
        address = 32'h40;
        data_in = 32'h1111_1111;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (stall && n < 50);
        check("done stall_cycles", 32'(n - 1), 32'h2);
        write   = 1'b0;
        read    = 1'b1;
        address = 32'h500;
        start   = hs_q.size();
        @(posedge clock);
        #1;
        read = 1'b0;
        @(negedge clock);
        check("done mem_read", 32'(mem_read), 32'h0);
        check("done stall", 32'(stall), 32'h0);
        @(negedge clock);
        check("done no_hs", 32'(hs_q.size() - start), 32'h0);
        v = '{1'b1, 1'b0, 32'h40, 32'h0, 0, 0, 32'h1111_1111, 32'h0};
        run_vec("done_hit", v);

        // Reset after the second refill handshake abandons the refill
        @(posedge clock);
        #1;
        read    = 1'b1;
        address = 32'h200;
        start   = hs_q.size();
        n = 0;
        while (hs_q.size() < start + 2 && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("rst_mid hs_before", 32'(hs_q.size() - start), 32'h2);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid mem_read", 32'(mem_read), 32'h0);
        check("rst_mid stall", 32'(stall), 32'h0);
        check("rst_mid mem_addr", mem_addr, 32'h0);
        read = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        v = '{1'b1, 1'b0, 32'h200, 32'h0, 5, 4, 32'hB0, 32'h200};
        run_vec("post_rst_refill", v);
        v = '{1'b1, 1'b0, 32'h20C, 32'h0, 0, 0, 32'hB3, 32'h0};
        run_vec("post_rst_hit", v);
        v = '{1'b1, 1'b0, 32'h40, 32'h0, 5, 4, 32'h1111_1111, 32'h40};
        run_vec("post_rst_cold", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the pipeline MEM stage (upstream) and the backing memory_cache/memory path (downstream).
- Serves read hits in the same cycle with no stall. Refills 4-word lines on read misses. Forwards every store to backing memory through a ready handshake.
- Its stall output replaces the MEM-stage stall source.

Parameters:
- LINES, 256, number of cache lines; power of two; IDX = log2(LINES).
- WORDS, 4, words per line; fixed at 4, giving a 2-bit word offset.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- read  input  1  CPU load request; held until stall is low.
- write  input  1  CPU store request; held until stall is low.
- address  input  32  CPU byte address. [1:0] ignored, [3:2] word offset, [IDX+3:4] index, [31:IDX+4] tag.
- data_in  input  32  store data.
- data_out  output  32  load data.
- stall  output  1  MEM stage must hold.
- mem_read  output  1  backing read request.
- mem_write  output  1  backing write request.
- mem_addr  output  32  backing word address, with [1:0]=0.
- mem_wdata  output  32  backing write data.
- mem_rdata  input  32  backing read data; valid when mem_ready is high.
- mem_ready  input  1  one-cycle pulse marking completion of the current backing access.

Behaviour:
- Storage:
  - Per line: valid bit, tag, 4x32 data.
  - hit = valid[index] & (tag[index] == address tag), evaluated combinationally.
- Reset (asynchronous):
  - All valid bits cleared, state=IDLE, word counter=0.
  - Outputs: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, data_out=0, stall=0.
  - Reset mid-refill or mid-write abandons the access. The partially refilled line stays invalid.
- States: IDLE, REFILL, WTHRU, DONE.
- IDLE:
  - read & ~write & hit: data_out = line word at the offset, in the same cycle; stall=0.
  - read & ~write & ~hit:
    - stall=1 combinationally in this cycle.
    - Latch tag and index; counter=0; next state REFILL.
  - write (takes priority over read when both are high):
    - stall=1 combinationally.
    - Latch address and data_in; next state WTHRU.
  - Neither request: stall=0, data_out=0.
- REFILL:
  - stall=1.
  - mem_read=1, mem_addr = {latched tag, latched index, counter, 2'b00}.
  - On each mem_ready: write mem_rdata into line word[counter], then counter++.
  - On mem_ready with counter==3: set valid and tag for the line, counter wraps to 0, next state IDLE.
  - In that IDLE cycle the request hits, so stall=0.
  - Total miss penalty = 4 handshakes + 1 cycle.
- WTHRU:
  - stall=1.
  - mem_write=1, mem_addr = latched word address, mem_wdata = latched data.
  - On mem_ready: if the line was a hit when latched, update the cached word; valid and tag are unchanged.
  - A write miss allocates nothing.
  - Next state DONE.
- DONE:
  - Exactly one cycle; stall=0 so the pipeline retires the store; data_out=0.
  - Next state IDLE.
  - Requests present in DONE are not evaluated.
- Handshake rules:
  - mem_read, mem_write, mem_addr and mem_wdata are registered.
  - They stay stable from assertion until the cycle mem_ready is sampled high.
  - mem_read and mem_write are never high together.
  - mem_ready outside REFILL/WTHRU is ignored.
- CPU address or data changing while stall=1 has no effect, because all values are latched.
- Line index wrap: index is taken modulo LINES; there is no aliasing beyond tag compare.

Test Plan:
- Cold read at 0x0000_0040, with memory words 0x40..0x4C holding 0xA0..0xA3:
  - stall high for 4 handshakes + 1 cycle.
  - mem_addr sequence 0x40, 0x44, 0x48, 0x4C.
  - Then data_out=0xA0 and stall=0.
- Read 0x0000_0048 immediately after that refill: data_out=0xA2 in the same cycle, stall=0, no mem_read.
- Write 0xDEADBEEF to 0x0000_0044 (hit):
  - mem_write with mem_addr=0x44 and mem_wdata=0xDEADBEEF.
  - stall drops for exactly one DONE cycle.
  - A following read of 0x44 returns 0xDEADBEEF with no refill.
- Write to 0x0001_0040 (same index, different tag, miss):
  - Memory is written.
  - A read of 0x0000_0040 still hits (line not replaced).
  - A read of 0x0001_0040 triggers a refill.
- Assert reset after the second mem_ready of a refill:
  - mem_read drops immediately.
  - After reset, a read of the same address misses and refills all 4 words.
- read and write asserted together at 0x80: treated as a write only (mem_write=1, no mem_read), DONE cycle, no line allocated.
